nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NUM_NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NUM_NIBBLES (16 at default).
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port io_in_valid  in  1  operand request valid.
REQ-005 SHALL have port io_in_ready  out  1  block can accept operands.
REQ-006 SHALL have port io_in_a  in  W  operand A.
REQ-007 SHALL have port io_in_b  in  W  operand B.
REQ-008 SHALL have port io_in_cin  in  1  carry-in for LSB nibble.
REQ-009 SHALL have port io_add_A  out  4  nibble of A to the external 4-bit ripple adder.
REQ-010 SHALL have port io_add_B  out  4  nibble of B to the external 4-bit ripple adder.
REQ-011 SHALL have port io_add_Cin  out  1  carry into the external adder.
REQ-012 SHALL have port io_add_Sum  in  4  combinational sum returned by the external adder, same cycle.
REQ-013 SHALL have port io_add_Cout  in  1  combinational carry-out returned by the external adder, same cycle.
REQ-014 SHALL have port io_out_valid  out  1  result valid.
REQ-015 SHALL have port io_out_ready  in  1  consumer accepts result.
REQ-016 SHALL have port io_out_sum  out  W  A+B+cin modulo 2^W.
REQ-017 SHALL have port io_out_cout  out  1  unsigned carry-out of the W-bit add.
REQ-018 SHALL have port io_out_ovf  out  1  two's-complement signed overflow.

Function
REQ-019 SHALL implement FSM states IDLE, ADD, DONE; reset state IDLE.
REQ-020 SHALL drive io_in_ready=1 only in IDLE; io_out_valid=1 only in DONE.
REQ-021 IDLE: on io_in_valid=1, SHALL latch io_in_a, io_in_b into operand registers, io_in_cin into carry register, clear nibble index to 0, go to ADD.
REQ-022 ADD: SHALL drive io_add_A/io_add_B = operand nibble [4*idx+3:4*idx], io_add_Cin = carry register.
REQ-023 ADD: each cycle SHALL write io_add_Sum into result nibble idx, load io_add_Cout into carry register, increment idx.
REQ-024 ADD with idx=NUM_NIBBLES-1: SHALL go to DONE after that cycle's capture; idx wraps to 0.
REQ-025 Latency SHALL be exactly NUM_NIBBLES+1 cycles from input handshake edge to io_out_valid=1 (5 at default).
REQ-026 DONE: io_out_sum = result register, io_out_cout = carry register, io_out_ovf = (A[W-1]==B[W-1]) && (sum[W-1]!=A[W-1]); all held stable until handshake.
REQ-027 DONE with io_out_ready=1: SHALL return to IDLE next cycle; no same-cycle re-accept (io_in_ready stays 0 in DONE).
REQ-028 io_in_valid while not IDLE SHALL be ignored; operand registers SHALL not change outside IDLE handshake.
REQ-029 In IDLE and DONE, io_add_A, io_add_B, io_add_Cin SHALL be 0.
REQ-030 io_out_sum, io_out_cout, io_out_ovf SHALL be 0 whenever io_out_valid=0.

Reset
REQ-031 reset=1 at any edge SHALL force IDLE, idx=0, clear operand, result and carry registers, regardless of state; an in-flight operation is discarded with no output.
REQ-032 Output values while and immediately after reset: io_in_ready=1, io_out_valid=0, io_out_sum=0, io_out_cout=0, io_out_ovf=0, io_add_*=0.

Verification (bench connects a 4-bit ripple adder model to io_add_*)
REQ-033 A=0x1234, B=0x4321, cin=0 -> io_out_valid 5 cycles after accept, sum=0x5555, cout=0, ovf=0.
REQ-034 A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; io_add_Cin=1 in ADD cycles 2-4.
REQ-035 A=0x7FFF, B=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; A=0xFFFF, B=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
REQ-036 Backpressure: io_out_ready=0 for 3 cycles in DONE, new io_in_valid pulses applied -> outputs stable, io_in_ready=0, pulses ignored; accepted on 4th cycle, IDLE next.
REQ-037 Reset in ADD at idx=2 -> next cycle IDLE, io_in_ready=1, io_out_valid=0, io_add_*=0; fresh 0x0001+0x0001 then yields 0x0002.
REQ-038 Back-to-back: two transactions with io_out_ready=1 held -> minimum initiation interval 6 cycles, both results correct.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder that reuses one external 4-bit ripple adder, one nibble per cycle.
// Accepts operands in IDLE, adds nibble by nibble in ADD, and holds the result in DONE.
module nibble_serial_adder #(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic [4*NUM_NIBBLES-1:0] io_in_a,
  input  logic [4*NUM_NIBBLES-1:0] io_in_b,
  input  logic                     io_in_cin,
  output logic [3:0]               io_add_A,
  output logic [3:0]               io_add_B,
  output logic                     io_add_Cin,
  input  logic [3:0]               io_add_Sum,
  input  logic                     io_add_Cout,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [4*NUM_NIBBLES-1:0] io_out_sum,
  output logic                     io_out_cout,
  output logic                     io_out_ovf
);

  localparam int W     = 4 * NUM_NIBBLES;
  localparam int IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;

  logic w_in_add;
  logic w_done;
  logic w_ovf;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_in_valid) begin
            r_a     <= io_in_a;
            r_b     <= io_in_b;
            r_carry <= io_in_cin;
            r_idx   <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum[4*r_idx +: 4] <= io_add_Sum;
          r_carry             <= io_add_Cout;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (io_out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_in_add = (r_state == S_ADD);
  assign w_done   = (r_state == S_DONE);
  assign w_ovf    = (r_a[W-1] == r_b[W-1]) && (r_sum[W-1] != r_a[W-1]);

  // Adder inputs and result outputs are forced to zero outside their owning state.
  assign io_in_ready  = (r_state == S_IDLE);
  assign io_add_A     = w_in_add ? r_a[4*r_idx +: 4] : 4'd0;
  assign io_add_B     = w_in_add ? r_b[4*r_idx +: 4] : 4'd0;
  assign io_add_Cin   = w_in_add & r_carry;
  assign io_out_valid = w_done;
  assign io_out_sum   = w_done ? r_sum : '0;
  assign io_out_cout  = w_done & r_carry;
  assign io_out_ovf   = w_done & w_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with a 4-bit ripple adder model on io_add_*
// and a queue of expected results scored when the DUT presents its output.
module tb_nibble_serial_adder;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [15:0] io_in_a;
  logic [15:0] io_in_b;
  logic        io_in_cin;
  logic [3:0]  io_add_A;
  logic [3:0]  io_add_B;
  logic        io_add_Cin;
  logic [3:0]  io_add_Sum;
  logic        io_add_Cout;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [15:0] io_out_sum;
  logic        io_out_cout;
  logic        io_out_ovf;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [15:0] sum;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  // External 4-bit ripple adder
  assign {io_add_Cout, io_add_Sum} = {1'b0, io_add_A} + {1'b0, io_add_B} + {4'd0, io_add_Cin};

  nibble_serial_adder #(.NUM_NIBBLES(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_a      (io_in_a),
    .io_in_b      (io_in_b),
    .io_in_cin    (io_in_cin),
    .io_add_A     (io_add_A),
    .io_add_B     (io_add_B),
    .io_add_Cin   (io_add_Cin),
    .io_add_Sum   (io_add_Sum),
    .io_add_Cout  (io_add_Cout),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_sum   (io_out_sum),
    .io_out_cout  (io_out_cout),
    .io_out_ovf   (io_out_ovf)
  );

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] t;
    res_t r;
    t      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    r.sum  = t[15:0];
    r.cout = t[16];
    r.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
    return r;
  endfunction

  // Carry into nibble i of a+b+cin
  function automatic logic carry_into(input logic [15:0] a, input logic [15:0] b,
                                      input logic cin, input int i);
    logic [16:0] mask;
    logic [16:0] t;
    mask = (17'd1 << (4 * i)) - 17'd1;
    t    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'd0, cin};
    return t[4*i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, {31'd0, io_in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, io_out_valid}, 32'd0);
    chk({tag, "_out_zero"}, {14'd0, io_out_ovf, io_out_cout, io_out_sum}, 32'd0);
    chk({tag, "_add_zero"}, {23'd0, io_add_Cin, io_add_B, io_add_A}, 32'd0);
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input bit push);
    int i;
    for (i = 0; i < 40 && !io_in_ready; i++) @(negedge clock);
    if (!io_in_ready) chk("accept_timeout", 32'd0, 32'd1);
    io_in_valid = 1'b1;
    io_in_a     = a;
    io_in_b     = b;
    io_in_cin   = cin;
    @(posedge clock);
    if (push) exp_q.push_back(model(a, b, cin));
    #1;
    io_in_valid = 1'b0;
  endtask

  task automatic chk_result(input string tag);
    res_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {14'd0, io_out_ovf, io_out_cout, io_out_sum}, {14'd0, e});
    end
  endtask

  // Accept, check each ADD cycle, check 5-cycle latency, hold ready low for `hold` cycles
  task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input int hold);
    res_t e;
    io_out_ready = 1'b0;
    accept(a, b, cin, 1'b1);
    e = model(a, b, cin);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk({tag, "_addA"}, {28'd0, io_add_A}, {28'd0, a[4*k +: 4]});
      chk({tag, "_addB"}, {28'd0, io_add_B}, {28'd0, b[4*k +: 4]});
      chk({tag, "_addCin"}, {31'd0, io_add_Cin}, {31'd0, carry_into(a, b, cin, k)});
      if (k == 3) chk({tag, "_early_valid"}, {31'd0, io_out_valid}, 32'd0);
    end
    @(negedge clock);
    chk({tag, "_latency_valid"}, {31'd0, io_out_valid}, 32'd1);
    chk({tag, "_add_zero_done"}, {23'd0, io_add_Cin, io_add_B, io_add_A}, 32'd0);
    chk_result({tag, "_result"});
    for (int h = 0; h < hold; h++) begin
      io_in_valid = 1'b1;
      io_in_a     = 16'hDEAD ^ 16'(h);
      io_in_b     = 16'hBEEF;
      io_in_cin   = 1'b1;
      @(negedge clock);
      chk({tag, "_bp_valid"}, {31'd0, io_out_valid}, 32'd1);
      chk({tag, "_bp_in_ready"}, {31'd0, io_in_ready}, 32'd0);
      chk({tag, "_bp_stable"}, {14'd0, io_out_ovf, io_out_cout, io_out_sum}, {14'd0, e});
    end
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    @(negedge clock);
    io_out_ready = 1'b0;
    chk_idle({tag, "_back_idle"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int ii;
    int lat;
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_a      = '0;
    io_in_b      = '0;
    io_in_cin    = 1'b0;
    io_out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk_idle("during_reset");
    reset = 1'b0;
    @(negedge clock);
    chk_idle("after_reset");

    run_txn("t1234", 16'h1234, 16'h4321, 1'b0, 0);
    run_txn("tffff_1", 16'hFFFF, 16'h0001, 1'b0, 0);
    run_txn("t7fff_1", 16'h7FFF, 16'h0001, 1'b0, 0);
    run_txn("tffff_ffff_c", 16'hFFFF, 16'hFFFF, 1'b1, 0);
    run_txn("tneg_ovf", 16'h8000, 16'h8000, 1'b0, 0);
    run_txn("backpressure", 16'hA5C3, 16'h1E2F, 1'b1, 3);

    // Reset in the middle of ADD (idx=2) discards the operation
    accept(16'h5A5A, 16'h1111, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("mid_add_A_idx2", {28'd0, io_add_A}, 32'hA);
    reset = 1'b1;
    @(negedge clock);
    chk_idle("reset_in_add");
    reset = 1'b0;
    @(negedge clock);
    chk_idle("reset_release");
    run_txn("after_abort", 16'h0001, 16'h0001, 1'b0, 0);

    // Back-to-back with ready held high: measure initiation interval
    io_out_ready = 1'b1;
    accept(16'h0F0F, 16'h0101, 1'b0, 1'b1);
    io_in_valid = 1'b1;
    io_in_a     = 16'h8001;
    io_in_b     = 16'hFFFF;
    io_in_cin   = 1'b1;
    ii = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (io_out_valid) chk_result("b2b_first");
      if (io_in_ready) begin
        ii = k;
        break;
      end
    end
    chk("b2b_interval", ii, 6);
    @(posedge clock);
    exp_q.push_back(model(16'h8001, 16'hFFFF, 1'b1));
    #1;
    io_in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (io_out_valid) begin
        lat = k;
        chk_result("b2b_second");
        break;
      end
    end
    chk("b2b_latency", lat, 5);
    @(negedge clock);
    chk_idle("b2b_idle");
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
